// File: rtl/hd_pkg.sv
// Shared definitions for the hard-disk responder: FSM states, default widths
// and latency constants.
package hd_pkg;

    localparam int unsigned DATA_W             = 32;
    localparam int unsigned DEF_TRACK_W        = 6;
    localparam int unsigned DEF_SECTOR_W       = 6;
    localparam int unsigned DEF_SEEK_CYCLES    = 8;
    localparam int unsigned DEF_ACCESS_CYCLES  = 2;
    localparam int unsigned DEF_PROTECT_TRACKS = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } hdState_t;

    // Larger of two latency constants, used to size the shared down-counter.
    function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hd_storage_ram.sv
// Disk media array: one 32-bit word per (track, sector), synchronous write,
// registered read.
module hd_storage_ram
    import hd_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_TRACK_W + DEF_SECTOR_W,
    parameter string       INIT_FILE = ""
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-first port: rdata reflects the word before any same-edge write.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/hd_responder.sv
// Hard-disk responder on the dataHD read path: serves word reads/writes
// addressed by (track, sector) with modelled seek and access latency.
// Optional build macro HD_PROTECT_EN makes tracks [0, PROTECT_TRACKS) read-only.
module hd_responder
    import hd_pkg::*;
#(
    parameter int unsigned TRACK_W        = DEF_TRACK_W,
    parameter int unsigned SECTOR_W       = DEF_SECTOR_W,
    parameter int unsigned SEEK_CYCLES    = DEF_SEEK_CYCLES,
    parameter int unsigned ACCESS_CYCLES  = DEF_ACCESS_CYCLES,
    parameter int unsigned PROTECT_TRACKS = DEF_PROTECT_TRACKS,
    parameter string       INIT_FILE      = ""
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [TRACK_W-1:0]  req_track,
    input  logic [SECTOR_W-1:0] req_sector,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                req_ready,
    output logic                rsp_valid,
    output logic                rsp_error,
    output logic [DATA_W-1:0]   dataHD,
    output logic                busy,
    output logic [TRACK_W-1:0]  head_track
);

    localparam int unsigned ADDR_W  = TRACK_W + SECTOR_W;
    localparam int unsigned CNT_MAX = maxOf(SEEK_CYCLES, ACCESS_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Reject configurations the latency model cannot represent.
    if (SEEK_CYCLES < 1 || ACCESS_CYCLES < 1) begin : gBadLatency
        $error("hd_responder: SEEK_CYCLES and ACCESS_CYCLES must be >= 1");
    end
    if (PROTECT_TRACKS > (1 << TRACK_W)) begin : gBadProtect
        $error("hd_responder: PROTECT_TRACKS exceeds the number of tracks");
    end

    hdState_t            stateQ, stateNext;
    logic [CNT_W-1:0]    cntQ, cntNext;
    logic                writeQ, writeNext;
    logic [TRACK_W-1:0]  trackQ, trackNext;
    logic [SECTOR_W-1:0] sectorQ, sectorNext;
    logic [DATA_W-1:0]   wdataQ, wdataNext;
    logic [TRACK_W-1:0]  headQ, headNext;
    logic [DATA_W-1:0]   dataQ, dataNext;
    logic                readyQ, readyNext;
    logic                busyQ, busyNext;
    logic                rspQ, rspNext;
    logic                errQ, errNext;
    logic                accept;
    logic                protectHit;
    logic                ramWe;
    logic [ADDR_W-1:0]   ramAddr;
    logic [DATA_W-1:0]   ramRdata;

    assign accept = req_valid & readyQ;

`ifdef HD_PROTECT_EN
    assign protectHit = req_write && (32'(req_track) < PROTECT_TRACKS);
`else
    assign protectHit = 1'b0;
`endif

    // In IDLE the RAM reads the incoming address so the word is ready even for a one-cycle access.
    assign ramAddr = (stateQ == IDLE) ? {req_track, req_sector} : {trackQ, sectorQ};

    hd_storage_ram #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) uRam (
        .clock (clock),
        .we    (ramWe & ~reset),
        .addr  (ramAddr),
        .wdata (wdataQ),
        .rdata (ramRdata)
    );

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ  <= IDLE;
            cntQ    <= '0;
            writeQ  <= 1'b0;
            trackQ  <= '0;
            sectorQ <= '0;
            wdataQ  <= '0;
            headQ   <= '0;
            dataQ   <= '0;
            readyQ  <= 1'b1;
            busyQ   <= 1'b0;
            rspQ    <= 1'b0;
            errQ    <= 1'b0;
        end else begin
            stateQ  <= stateNext;
            cntQ    <= cntNext;
            writeQ  <= writeNext;
            trackQ  <= trackNext;
            sectorQ <= sectorNext;
            wdataQ  <= wdataNext;
            headQ   <= headNext;
            dataQ   <= dataNext;
            readyQ  <= readyNext;
            busyQ   <= busyNext;
            rspQ    <= rspNext;
            errQ    <= errNext;
        end
    end

    // Next-state, counter, latch and output decode.
    always_comb begin
        stateNext  = stateQ;
        cntNext    = cntQ;
        writeNext  = writeQ;
        trackNext  = trackQ;
        sectorNext = sectorQ;
        wdataNext  = wdataQ;
        headNext   = headQ;
        dataNext   = dataQ;
        errNext    = 1'b0;
        ramWe      = 1'b0;

        unique case (stateQ)
            IDLE: begin
                if (accept) begin
                    writeNext  = req_write;
                    trackNext  = req_track;
                    sectorNext = req_sector;
                    wdataNext  = req_wdata;
                    if (protectHit) begin
                        stateNext = RESP;
                        errNext   = 1'b1;
                    end else if (req_track != headQ) begin
                        stateNext = SEEK;
                        cntNext   = CNT_W'(SEEK_CYCLES - 1);
                    end else begin
                        stateNext = ACCESS;
                        cntNext   = CNT_W'(ACCESS_CYCLES - 1);
                    end
                end
            end
            SEEK: begin
                if (cntQ == '0) begin
                    stateNext = ACCESS;
                    cntNext   = CNT_W'(ACCESS_CYCLES - 1);
                    headNext  = trackQ;
                end else begin
                    cntNext = cntQ - CNT_W'(1);
                end
            end
            ACCESS: begin
                if (cntQ == '0) begin
                    stateNext = RESP;
                    if (writeQ) begin
                        ramWe = 1'b1;
                    end else begin
                        dataNext = ramRdata;
                    end
                end else begin
                    cntNext = cntQ - CNT_W'(1);
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        readyNext = (stateNext == IDLE);
        busyNext  = (stateNext != IDLE);
        rspNext   = (stateNext == RESP);
    end

    assign req_ready  = readyQ;
    assign busy       = busyQ;
    assign rsp_valid  = rspQ;
    assign rsp_error  = errQ;
    assign dataHD     = dataQ;
    assign head_track = headQ;

endmodule

// File: tb/tb_hd_responder.sv
// Directed bench for hd_responder: latency, data path, reset abort,
// write protection (HD_PROTECT_EN) and request holding while busy.
module tb_hd_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [5:0]  req_track;
    logic [5:0]  req_sector;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_error;
    logic [31:0] dataHD;
    logic        busy;
    logic [5:0]  head_track;

    int errCnt = 0;
    int chkCnt = 0;

    always #5 clock = ~clock;

    hd_responder dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_track  (req_track),
        .req_sector (req_sector),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_error  (rsp_error),
        .dataHD     (dataHD),
        .busy       (busy),
        .head_track (head_track)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    // Called at the negedge right after the accept edge; lat=1 means rsp_valid in cycle T+1.
    task automatic waitRsp(output int lat, output logic err);
        lat = 1;
        while (!rsp_valid && lat <= 40) begin
            @(negedge clock);
            lat++;
        end
        err = rsp_error;
    endtask

    // One request issued from an IDLE negedge; returns at the following IDLE negedge.
    task automatic doReq(input string tag, input logic wr, input int trk, input int sec,
                         input logic [31:0] wd, input int expLat, input logic expErr);
        int   lat;
        logic err;
        req_valid  = 1'b1;
        req_write  = wr;
        req_track  = 6'(trk);
        req_sector = 6'(sec);
        req_wdata  = wd;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        req_write = 1'b0;
        req_wdata = 32'h0;
        waitRsp(lat, err);
        check({tag, " latency"}, 32'(lat), 32'(expLat));
        check({tag, " rsp_error"}, 32'(err), 32'(expErr));
        @(negedge clock);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " rsp_error"}, 32'(rsp_error), 32'd0);
        check({tag, " dataHD"}, dataHD, 32'h0);
        check({tag, " head_track"}, 32'(head_track), 32'd0);
    endtask

    initial begin
        int   lat;
        int   rspSeen;
        logic err;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_track  = '0;
        req_sector = '0;
        req_wdata  = '0;

        // Known media contents: index = {track, sector}
        dut.uRam.mem[{6'd0, 6'd5}] = 32'hCAFE0001;
        dut.uRam.mem[{6'd3, 6'd0}] = 32'h30300000;
        dut.uRam.mem[{6'd5, 6'd1}] = 32'hA5A5A5A5;
        dut.uRam.mem[{6'd0, 6'd9}] = 32'h11111111;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkResetOutputs("reset");

        // 1: same-track read at head 0
        doReq("t1 read t0s5", 1'b0, 0, 5, 32'h0, 3, 1'b0);
        check("t1 dataHD", dataHD, 32'hCAFE0001);
        check("t1 head", 32'(head_track), 32'd0);

        // 2: seek to track 3, then same-track read
        doReq("t2 read t3s0 seek", 1'b0, 3, 0, 32'h0, 11, 1'b0);
        check("t2 head", 32'(head_track), 32'd3);
        check("t2 dataHD", dataHD, 32'h30300000);
        doReq("t2 read t3s0 again", 1'b0, 3, 0, 32'h0, 3, 1'b0);

        // 3: write then read back; the write leaves dataHD alone
        doReq("t3 write t2s7", 1'b1, 2, 7, 32'h12345678, 11, 1'b0);
        check("t3 dataHD after write", dataHD, 32'h30300000);
        check("t3 head", 32'(head_track), 32'd2);
        doReq("t3 read t2s7", 1'b0, 2, 7, 32'h0, 3, 1'b0);
        check("t3 dataHD readback", dataHD, 32'h12345678);

        // 4: reset four cycles into a write seek
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_track  = 6'd5;
        req_sector = 6'd1;
        req_wdata  = 32'hFFFF0000;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        req_write = 1'b0;
        rspSeen   = 0;
        repeat (3) begin
            if (rsp_valid) rspSeen++;
            @(negedge clock);
        end
        if (rsp_valid) rspSeen++;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkResetOutputs("t4 in reset");
        reset = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (rsp_valid) rspSeen++;
        end
        check("t4 no rsp_valid", 32'(rspSeen), 32'd0);
        check("t4 idle req_ready", 32'(req_ready), 32'd1);
        doReq("t4 read t5s1", 1'b0, 5, 1, 32'h0, 11, 1'b0);
        check("t4 word unchanged", dataHD, 32'hA5A5A5A5);

        // 5: write to track 0
`ifdef HD_PROTECT_EN
        doReq("t5 protected write t0s9", 1'b1, 0, 9, 32'h99999999, 1, 1'b1);
        check("t5 head unchanged", 32'(head_track), 32'd5);
        check("t5 dataHD unchanged", dataHD, 32'hA5A5A5A5);
        doReq("t5 read t0s9", 1'b0, 0, 9, 32'h0, 11, 1'b0);
        check("t5 mem unchanged", dataHD, 32'h11111111);
`else
        doReq("t5 write t0s9", 1'b1, 0, 9, 32'h99999999, 11, 1'b0);
        check("t5 head", 32'(head_track), 32'd0);
        doReq("t5 read t0s9", 1'b0, 0, 9, 32'h0, 3, 1'b0);
        check("t5 mem committed", dataHD, 32'h99999999);
`endif

        // 6: req_valid held through busy with changing fields
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_track  = 6'd2;
        req_sector = 6'd7;
        req_wdata  = 32'h0;
        @(posedge clock);
        @(negedge clock);
        lat = 1;
        while (!rsp_valid && lat <= 40) begin
            if (lat < 4) begin
                req_write  = 1'b1;
                req_track  = 6'(lat + 10);
                req_sector = 6'(lat);
                req_wdata  = 32'(lat);
            end else begin
                req_write  = 1'b1;
                req_track  = 6'd2;
                req_sector = 6'd8;
                req_wdata  = 32'hDEADBEEF;
            end
            @(negedge clock);
            lat++;
        end
        check("t6 first latency", 32'(lat), 32'd11);
        check("t6 first dataHD", dataHD, 32'h12345678);
        check("t6 first rsp_error", 32'(rsp_error), 32'd0);
        @(negedge clock);
        check("t6 idle after resp", 32'(req_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        req_write = 1'b0;
        check("t6 second accepted", 32'(busy), 32'd1);
        waitRsp(lat, err);
        check("t6 second latency", 32'(lat), 32'd3);
        check("t6 second rsp_error", 32'(err), 32'd0);
        check("t6 dataHD after write", dataHD, 32'h12345678);
        @(negedge clock);
        doReq("t6 read t2s8", 1'b0, 2, 8, 32'h0, 3, 1'b0);
        check("t6 second write data", dataHD, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
